data_ram_arbiter: RTL
=====================

# data_ram_arbiter

Shares the single-port 32x32 data RAM between the CPU load/store port and a byte-serial host debug port. The host port streams whole 32-bit words into or out of the RAM one byte per transfer. The block sits between the `risc` core, the data RAM and the tile pins. The CPU port and the host port contend for the RAM cycle by cycle under round-robin arbitration.

## Interface
Parameters:
- `ADDR_W`, default 5: RAM word-address width (32 words).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `cpu_req` in 1: CPU requests a RAM access this cycle.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_gnt` out 1: combinational; the CPU access executes this cycle. CPU stalls while `cpu_req & !cpu_gnt`.
- `cpu_rvalid` out 1: registered; high the cycle after a granted CPU read.
- `cpu_rdata` out 32: passthrough of `ram_rdata`; meaningful when `cpu_rvalid`.
- `host_start` in 1: starts a host word transaction; ignored while `host_busy`.
- `host_we` in 1: sampled with `host_start`; 1 = write word, 0 = read word.
- `host_addr` in ADDR_W: sampled with `host_start`.
- `host_byte_valid` in 1: a write byte is present on `host_wbyte`.
- `host_wbyte` in 8: write byte, LSB lane first.
- `host_rbyte` out 8: read byte, LSB lane first; registered.
- `host_rbyte_valid` out 1: `host_rbyte` valid this cycle.
- `host_busy` out 1: host FSM not in H_IDLE.
- `host_done` out 1: one-cycle completion pulse.
- `ram_we` out 1, `ram_addr` out ADDR_W, `ram_wdata` out 32: combinational RAM port drive.
- `ram_rdata` in 32: RAM read data, valid one cycle after the address cycle.

## Operation
- **Host FSM states:**
  - H_IDLE → H_COLLECT on `host_start & host_we`.
  - H_IDLE → H_RREQ on `host_start & !host_we`.
  - On either start, latch `host_addr` and clear the byte counter `idx`.
- **H_COLLECT:**
  - Each cycle with `host_byte_valid`, store `host_wbyte` into lane `idx` of the word buffer and increment `idx`.
  - The 4th accepted byte (idx = 3) moves the FSM to H_WREQ.
  - `host_byte_valid` is ignored in every other state, including the `host_start` cycle.
- **H_WREQ:** requests the RAM for a write of the buffer to the latched address. On grant → H_IDLE and `host_done` pulses.
- **H_RREQ:** requests the RAM for a read. On grant → H_RWAIT.
- **H_RWAIT:** latch `ram_rdata` into the buffer and set `idx` = 0 → H_STREAM.
- **H_STREAM:**
  - Each cycle, the registered outputs present `host_rbyte` = buffer lane `idx` with `host_rbyte_valid` = 1.
  - Bytes go out on 4 consecutive cycles with no backpressure.
  - After lane 3 → H_IDLE with `host_done` pulse.
- **Arbiter:**
  - Requesters are `cpu_req` and host FSM in H_WREQ/H_RREQ.
  - A lone requester is granted immediately.
  - On conflict, the requester not granted at the previous conflict wins.
  - The `last` pointer updates only on conflict cycles and resets to HOST, so the CPU wins the first conflict.
- **RAM drive:**
  - `ram_addr`, `ram_we` and `ram_wdata` come from the granted requester.
  - With no grant: `ram_we` = 0 and address/data = 0.
  - `ram_we` is forced to 0 while `rst`.
- The host port does not occupy the RAM during H_COLLECT, H_RWAIT or H_STREAM; CPU accesses proceed freely in those states.

## Timing
- **Reset values:**
  - `cpu_gnt`, `cpu_rvalid`, `host_busy`, `host_done`, `host_rbyte_valid`, `ram_we` = 0.
  - `host_rbyte` = 8'h00; `last` = HOST; FSM = H_IDLE.
- **Reset mid-transaction:** collected bytes are discarded, no RAM write occurs, and any stream stops the following cycle.
- **Host write, uncontended:**
  - `host_start` in cycle 0; bytes are accepted from cycle 1.
  - 4th byte in cycle t; RAM write in t+1.
  - `host_done` = 1 and `host_busy` = 0 in t+2; a new `host_start` is accepted in t+2.
- **Host read, uncontended:**
  - `host_start` in cycle 0; RAM address cycle 1; data latched in cycle 2.
  - Bytes 0..3 in cycles 3..6; `host_done` in cycle 7.
- **CPU read:** granted in cycle n; `cpu_rvalid` with data in cycle n+1. A CPU write completes in its grant cycle.
- **Bounded wait:** under continuous `cpu_req`, a host request waits at most 1 cycle, and vice versa.
- **Cycle counts:** `idx` is 2 bits; the host write buffer and read buffer share storage. The host port has no address increment; each transaction is exactly one word.

## Test plan
- **Host write then CPU read:**
  - Host writes bytes 0x78, 0x56, 0x34, 0x12 to address 5 with the CPU idle.
  - Required: `ram_we` one cycle with `ram_wdata` = 0x12345678.
  - Then CPU reads address 5 → `cpu_rvalid` next cycle with `cpu_rdata` = 0x12345678.
- **CPU write then host read:**
  - CPU writes 0xDEADBEEF to address 31, then host reads address 31.
  - Required: `host_rbyte` = EF, BE, AD, DE on cycles 3..6; `host_done` on cycle 7.
- **Conflict, CPU first:**
  - `cpu_req` held high continuously while a host write reaches H_WREQ.
  - Required: the first conflict grants the CPU, the next cycle grants the host; the CPU stalls exactly 1 cycle.
- **Gapped bytes:**
  - Host write bytes arrive with 2-cycle gaps; `host_byte_valid` is also pulsed during the `host_start` cycle and during H_IDLE.
  - Required: only 4 bytes in H_COLLECT are stored, and the word is correct.
- **Reset mid-collect:**
  - Assert `rst` after 2 of 4 bytes.
  - Required: all outputs return to reset values, no `ram_we` pulse, and a later read of that address returns its old value.
- **Start while busy:** `host_start` pulsed while `host_busy` is high is ignored; the latched address and direction are unchanged.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//
// Shares the single-port data RAM between the CPU load/store port and a
// byte-serial host debug port. The host port moves one whole 32-bit word per
// transaction, one byte per transfer, LSB lane first. Both ports contend for
// the RAM cycle by cycle under round-robin arbitration.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata : CPU access request (executes in its grant cycle)
//   cpu_gnt             : combinational grant; CPU stalls while req & !gnt
//   cpu_rvalid          : registered, high the cycle after a granted CPU read
//   cpu_rdata           : passthrough of ram_rdata
//   host_start/we/addr  : starts a host word transaction (ignored while busy)
//   host_byte_valid     : write byte present on host_wbyte
//   host_wbyte          : write byte, LSB lane first
//   host_rbyte(_valid)  : registered read byte stream, LSB lane first
//   host_busy           : host FSM not idle
//   host_done           : one-cycle completion pulse
//   ram_we/addr/wdata   : combinational RAM port drive
//   ram_rdata           : RAM read data, one cycle after the address cycle
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              host_start,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_byte_valid,
  input  logic [7:0]        host_wbyte,
  output logic [7:0]        host_rbyte,
  output logic              host_rbyte_valid,
  output logic              host_busy,
  output logic              host_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    H_IDLE    = 3'd0,
    H_COLLECT = 3'd1,
    H_WREQ    = 3'd2,
    H_RREQ    = 3'd3,
    H_RWAIT   = 3'd4,
    H_STREAM  = 3'd5
  } host_state_e;

  host_state_e       state_r;
  host_state_e       state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        idx_r;
  // Shared by the write collector and the read streamer.
  logic [31:0]       buf_r;
  // 1: the host won the most recent conflict; 0: the CPU did.
  logic              last_host_r;
  logic              cpu_rvalid_r;
  logic              host_done_r;
  logic              host_rbyte_valid_r;
  logic [7:0]        host_rbyte_r;

  logic              host_req_s;
  logic              conflict_s;
  logic              gnt_cpu_s;
  logic              gnt_host_s;

  // Extract byte lane `lane` from a word.
  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Replace byte lane `lane` of a word with `b`.
  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w = word;
    endcase
    return w;
  endfunction

  // Round-robin arbiter between the CPU and the host request states.
  always_comb begin
    host_req_s = 1'b0;
    conflict_s = 1'b0;
    gnt_cpu_s  = 1'b0;
    gnt_host_s = 1'b0;
    if (rst) begin
      // Nothing may reach the RAM while reset is held.
      gnt_cpu_s  = 1'b0;
      gnt_host_s = 1'b0;
    end else begin
      host_req_s = (state_r == H_WREQ) || (state_r == H_RREQ);
      conflict_s = cpu_req && host_req_s;
      if (conflict_s) begin
        // The loser of the previous conflict wins this one.
        gnt_host_s = !last_host_r;
        gnt_cpu_s  = last_host_r;
      end else begin
        gnt_cpu_s  = cpu_req;
        gnt_host_s = host_req_s;
      end
    end
  end

  // RAM port mux: driven by whichever requester holds the grant.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = 32'h0000_0000;
    if (gnt_cpu_s) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (gnt_host_s) begin
      ram_we    = (state_r == H_WREQ);
      ram_addr  = addr_r;
      ram_wdata = (state_r == H_WREQ) ? buf_r : 32'h0000_0000;
    end else begin
      ram_we    = 1'b0;
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = 32'h0000_0000;
    end
  end

  // Host FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      H_IDLE: begin
        if (host_start) begin
          state_next_s = host_we ? H_COLLECT : H_RREQ;
        end else begin
          state_next_s = H_IDLE;
        end
      end
      H_COLLECT: begin
        if (host_byte_valid && (idx_r == 2'd3)) begin
          state_next_s = H_WREQ;
        end else begin
          state_next_s = H_COLLECT;
        end
      end
      H_WREQ: begin
        if (gnt_host_s) begin
          state_next_s = H_IDLE;
        end else begin
          state_next_s = H_WREQ;
        end
      end
      H_RREQ: begin
        if (gnt_host_s) begin
          state_next_s = H_RWAIT;
        end else begin
          state_next_s = H_RREQ;
        end
      end
      H_RWAIT: begin
        state_next_s = H_STREAM;
      end
      H_STREAM: begin
        if (idx_r == 2'd3) begin
          state_next_s = H_IDLE;
        end else begin
          state_next_s = H_STREAM;
        end
      end
      default: begin
        state_next_s = H_IDLE;
      end
    endcase
  end

  // FSM state and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= H_IDLE;
      last_host_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (conflict_s) begin
        last_host_r <= gnt_host_s;
      end
    end
  end

  // Host datapath: latched address, byte index and the shared word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= {ADDR_W{1'b0}};
      idx_r  <= 2'd0;
      buf_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        H_IDLE: begin
          if (host_start) begin
            addr_r <= host_addr;
            idx_r  <= 2'd0;
          end
        end
        H_COLLECT: begin
          if (host_byte_valid) begin
            buf_r <= lane_put(buf_r, idx_r, host_wbyte);
            idx_r <= idx_r + 2'd1;
          end
        end
        H_RWAIT: begin
          buf_r <= ram_rdata;
          idx_r <= 2'd0;
        end
        H_STREAM: begin
          idx_r <= idx_r + 2'd1;
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Registered outputs: CPU read-valid, host byte stream and done pulse.
  // The byte register is loaded one cycle ahead so that it shows lane idx
  // while the FSM sits in H_STREAM with that idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_r       <= 1'b0;
      host_done_r        <= 1'b0;
      host_rbyte_valid_r <= 1'b0;
      host_rbyte_r       <= 8'h00;
    end else begin
      cpu_rvalid_r <= gnt_cpu_s && !cpu_we;
      host_done_r  <= ((state_r == H_WREQ) && gnt_host_s) ||
                      ((state_r == H_STREAM) && (idx_r == 2'd3));
      case (state_r)
        H_RWAIT: begin
          host_rbyte_r       <= ram_rdata[7:0];
          host_rbyte_valid_r <= 1'b1;
        end
        H_STREAM: begin
          if (idx_r != 2'd3) begin
            host_rbyte_r       <= lane_get(buf_r, idx_r + 2'd1);
            host_rbyte_valid_r <= 1'b1;
          end else begin
            host_rbyte_valid_r <= 1'b0;
          end
        end
        default: begin
          host_rbyte_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_gnt          = gnt_cpu_s;
  assign cpu_rvalid       = cpu_rvalid_r;
  assign cpu_rdata        = ram_rdata;
  assign host_rbyte       = host_rbyte_r;
  assign host_rbyte_valid = host_rbyte_valid_r;
  assign host_busy        = (state_r != H_IDLE);
  assign host_done        = host_done_r;

endmodule
